// File: rtl/wc_rr_fifo_scheduler_pkg.sv
// Shared constants and types for the four-queue work-conserving round-robin read scheduler.
// No logic lives here; the latency and backpressure behaviour are described in the top-level header.
package wc_rr_fifo_scheduler_pkg;

    localparam int NPORT     = 4;
    localparam int PW        = 2;
    localparam int CW        = 4;
    localparam int QUOTA_MIN = 1;
    localparam int QUOTA_MAX = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_e;

    // An out-of-range QUOTA is pulled into the range the 4-bit burst counter can represent.
    function automatic int clamp_quota(input int q);
        if (q < QUOTA_MIN) begin
            return QUOTA_MIN;
        end
        if (q > QUOTA_MAX) begin
            return QUOTA_MAX;
        end
        return q;
    endfunction

endpackage

// File: rtl/wc_rr_fifo_scheduler_if.sv
// Bundle between the four input queues, the shared consumer and the scheduler.
// The master modport is the scheduler; the slave modport is the queue/consumer side.
interface wc_rr_fifo_scheduler_if #(
    parameter int DW = 8
);
    import wc_rr_fifo_scheduler_pkg::*;

    logic [NPORT-1:0]    req;
    logic [NPORT-1:0]    wen;
    logic [NPORT*DW-1:0] din;
    logic                ready;
    logic [NPORT-1:0]    ren;
    logic [DW-1:0]       dout;
    logic                valid;
    logic [PW-1:0]       grant_id;

    modport master (
        input  req,
        input  wen,
        input  din,
        input  ready,
        output ren,
        output dout,
        output valid,
        output grant_id
    );

    modport slave (
        output req,
        output wen,
        output din,
        output ready,
        input  ren,
        input  dout,
        input  valid,
        input  grant_id
    );

endinterface

// File: rtl/wc_rr_fifo_scheduler_rr_pick.sv
// Rotating-priority pick: the first eligible port scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
// Purely combinational; an all-zero eligible vector yields no grant.
module wc_rr_fifo_scheduler_rr_pick
    import wc_rr_fifo_scheduler_pkg::*;
(
    input  logic [NPORT-1:0] i_elig,
    input  logic [PW-1:0]    i_ptr,
    output logic [NPORT-1:0] o_gnt,
    output logic [PW-1:0]    o_gid
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        o_gid   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
            w_idx = i_ptr + PW'(k);
            if (!w_found && i_elig[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gid        = w_idx;
            end
        end
    end

endmodule

// File: rtl/wc_rr_fifo_scheduler.sv
// Work-conserving RR read scheduler: ren is combinational and the word appears one cycle later with valid.
// ready is a next-cycle acceptance: ready=0 blocks ren and freezes the rotation state.
module wc_rr_fifo_scheduler
    import wc_rr_fifo_scheduler_pkg::*;
#(
    parameter int DW    = 8,
    parameter int QUOTA = 1
)
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    wc_rr_fifo_scheduler_if.master io_q
);

    localparam int          QEFF    = clamp_quota(QUOTA);
    localparam logic [CW:0] QUOTA_W = (CW + 1)'(QEFF);

    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [PW-1:0]    r_grant_id;

    logic [NPORT-1:0] w_elig;
    logic [NPORT-1:0] w_gnt;
    logic [PW-1:0]    w_gid;
    logic             w_any;
    sched_state_e     w_state;
    logic [PW-1:0]    w_ptr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [DW-1:0]    w_dout;

    // A queue being written this cycle cannot also be read, so it sits out this round.
    assign w_elig  = (i_rst || !io_q.ready) ? '0 : (io_q.req & ~io_q.wen);
    assign w_any   = |w_gnt;
    assign w_state = (r_cnt == '0) ? ST_IDLE : ST_BURST;

    wc_rr_fifo_scheduler_rr_pick u_rr_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_gid  (w_gid)
    );

    assign io_q.ren = w_gnt;

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        if (w_any) begin
            if ((w_gid == r_ptr) && (({1'b0, r_cnt} + (CW + 1)'(1)) < QUOTA_W)) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end else if ((w_gid != r_ptr) && (QEFF > 1)) begin
                // Another port took over: it becomes the new holder with one grant spent.
                w_ptr_nxt = w_gid;
                w_cnt_nxt = CW'(1);
            end else begin
                w_ptr_nxt = w_gid + PW'(1);
                w_cnt_nxt = '0;
            end
        end else if (io_q.ready && (w_state == ST_BURST)) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_grant_id <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_any;
            if (w_any) begin
                r_grant_id <= w_gid;
            end
        end
    end

    always_comb begin
        w_dout = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (r_valid && (r_grant_id == PW'(i))) begin
                w_dout = io_q.din[i*DW +: DW];
            end
        end
    end

    assign io_q.dout     = w_dout;
    assign io_q.valid    = r_valid;
    assign io_q.grant_id = r_grant_id;

endmodule

// File: tb/tb_wc_rr_fifo_scheduler.sv
// Bench for wc_rr_fifo_scheduler: three instances (QUOTA 1, 3, 4) share one stimulus stream
// and are checked against a behavioural model of favoured port and burst usage.
module tb_wc_rr_fifo_scheduler;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [3:0]  req;
    logic [3:0]  wen;
    logic [31:0] din;

    logic [3:0]  o_ren  [3];
    logic        o_vld  [3];
    logic [1:0]  o_gid  [3];
    logic [7:0]  o_dout [3];

    int n_total = 0;
    int n_bad   = 0;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        localparam int Q = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        wc_rr_fifo_scheduler_if #(.DW(8)) bus ();
        assign bus.req   = req;
        assign bus.wen   = wen;
        assign bus.din   = din;
        assign bus.ready = ready;
        assign o_ren[g]  = bus.ren;
        assign o_vld[g]  = bus.valid;
        assign o_gid[g]  = bus.grant_id;
        assign o_dout[g] = bus.dout;
        wc_rr_fifo_scheduler #(.DW(8), .QUOTA(Q)) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .io_q  (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: favoured port, grants it has used in its current burst, last output word.
    int   q_of   [3] = '{1, 3, 4};
    int   m_fav  [3];
    int   m_used [3];
    bit   m_vld  [3];
    int   m_gid  [3];
    int   e_pick [3];
    logic [3:0] e_ren  [3];
    logic       e_vld  [3];
    logic [1:0] e_gid  [3];
    logic [7:0] e_dout [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_fav[d] = 0; m_used[d] = 0; m_vld[d] = 1'b0; m_gid[d] = 0;
        end
    endfunction

    function automatic void model_eval();
        logic [3:0] elig;
        int p;
        elig = (rst || !ready) ? 4'b0000 : (req & ~wen);
        for (int d = 0; d < 3; d++) begin
            e_pick[d] = -1;
            for (int k = 0; k < 4; k++) begin
                p = (m_fav[d] + k) % 4;
                if (e_pick[d] < 0 && elig[p]) e_pick[d] = p;
            end
            e_ren[d]  = (e_pick[d] < 0) ? 4'b0000 : 4'(1 << e_pick[d]);
            e_vld[d]  = m_vld[d];
            e_gid[d]  = 2'(m_gid[d]);
            e_dout[d] = m_vld[d] ? din[m_gid[d]*8 +: 8] : 8'h00;
        end
    endfunction

    function automatic void model_update();
        int p;
        if (rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            p = e_pick[d];
            m_vld[d] = (p >= 0);
            if (p >= 0) begin
                m_gid[d] = p;
                if (p == m_fav[d] && m_used[d] + 1 < q_of[d]) begin
                    m_used[d] = m_used[d] + 1;
                end else if (p != m_fav[d] && q_of[d] > 1) begin
                    m_fav[d] = p; m_used[d] = 1;
                end else begin
                    m_fav[d] = (p + 1) % 4; m_used[d] = 0;
                end
            end else if (ready) begin
                m_used[d] = 0;
            end
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
        din = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; wen = 4'h0; ready = 1'b1;
        model_reset();
        tick();
        #2;
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if ({o_ren[d], o_vld[d], o_gid[d], o_dout[d]} !== 15'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d ren=%b vld=%b gid=%0d dout=%h exp all zero",
                         d, o_ren[d], o_vld[d], o_gid[d], o_dout[d]);
            end
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rr_q1();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'hF; wen = 4'h0; ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2; model_eval();
            n_total++;
            if (o_ren[0] !== seq[i]) begin
                n_bad++; $display("FAIL rr_q1_ren cyc%0d got=%b exp=%b", i, o_ren[0], seq[i]);
            end
            if (i > 0) begin
                n_total++;
                if ({o_vld[0], o_gid[0]} !== {1'b1, 2'(i - 1)}) begin
                    n_bad++; $display("FAIL rr_q1_out cyc%0d vld=%b gid=%0d exp vld=1 gid=%0d",
                                      i, o_vld[0], o_gid[0], i - 1);
                end
            end
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if ({o_ren[d], o_vld[d], o_gid[d], o_dout[d]} !== {e_ren[d], e_vld[d], e_gid[d], e_dout[d]}) begin
                    n_bad++; $display("FAIL rr_q1_model dut%0d cyc%0d got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", d, i,
                                      o_ren[d], o_vld[d], o_gid[d], o_dout[d], e_ren[d], e_vld[d], e_gid[d], e_dout[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        req = 4'b0101; wen = 4'h0; ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2; model_eval();
            n_total++;
            if (o_ren[0] !== 4'b0001 && o_ren[0] !== 4'b0100) begin
                n_bad++; $display("FAIL alt_ren cyc%0d got=%b exp 0001 or 0100", i, o_ren[0]);
            end
            n_total++;
            if (o_ren[0] !== e_ren[0]) begin
                n_bad++; $display("FAIL alt_model cyc%0d got=%b exp=%b", i, o_ren[0], e_ren[0]);
            end
            tick();
        end
    endtask

    task automatic test_quota3();
        int seq [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        do_reset();
        req = 4'hF; wen = 4'h0; ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #2;
            n_total++;
            if (o_ren[1] !== 4'(1 << seq[i])) begin
                n_bad++; $display("FAIL q3_ren cyc%0d got=%b exp port %0d", i, o_ren[1], seq[i]);
            end
            tick();
        end
        do_reset();
        req = 4'hF;
        tick();
        tick();
        req = 4'b1110;
        #2;
        n_total++;
        if (o_ren[1] !== 4'b0010) begin
            n_bad++; $display("FAIL q3_drain got=%b exp=0010", o_ren[1]);
        end
        tick();
    endtask

    task automatic test_wen_skip();
        do_reset();
        req = 4'b0011; wen = 4'b0001; ready = 1'b1;
        #2;
        n_total++;
        if (o_ren[0] !== 4'b0010) begin
            n_bad++; $display("FAIL wen_skip got=%b exp=0010", o_ren[0]);
        end
        tick();
        wen = 4'h0;
        #2;
        n_total++;
        if (o_ren[0] !== 4'b0001) begin
            n_bad++; $display("FAIL wen_wrap got=%b exp=0001", o_ren[0]);
        end
        tick();
    endtask

    task automatic test_ready_stall();
        logic [3:0] exp_ren [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0010};
        logic       exp_vld [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        req = 4'hF; wen = 4'h0; ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            ready = (i >= 3);
            #2;
            n_total++;
            if ({o_ren[1], o_vld[1]} !== {exp_ren[i], exp_vld[i]}) begin
                n_bad++; $display("FAIL stall cyc%0d ren=%b vld=%b exp ren=%b vld=%b",
                                  i, o_ren[1], o_vld[1], exp_ren[i], exp_vld[i]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'hF; wen = 4'h0; ready = 1'b1;
        repeat (6) tick();
        #2;
        n_total++;
        if ({o_vld[2], o_gid[2]} !== 3'b1_01) begin
            n_bad++; $display("FAIL pre_rst vld=%b gid=%0d exp vld=1 gid=1", o_vld[2], o_gid[2]);
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if ({o_ren[2], o_vld[2], o_gid[2], o_dout[2]} !== 15'b0) begin
            n_bad++; $display("FAIL async_rst ren=%b vld=%b gid=%0d dout=%h exp all zero",
                              o_ren[2], o_vld[2], o_gid[2], o_dout[2]);
        end
        tick();
        rst = 1'b0;
        #2;
        n_total++;
        if (o_ren[2] !== 4'b0001) begin
            n_bad++; $display("FAIL post_rst_ren got=%b exp=0001", o_ren[2]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 9) != 0);
            req   = 4'($urandom) | 4'($urandom);
            wen   = 4'($urandom) & 4'($urandom);
            #2; model_eval();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (o_ren[d] !== e_ren[d]) begin
                    n_bad++; $display("FAIL rand_ren dut%0d cyc%0d got=%b exp=%b", d, i, o_ren[d], e_ren[d]);
                end
                n_total++;
                if ({o_vld[d], o_gid[d], o_dout[d]} !== {e_vld[d], e_gid[d], e_dout[d]}) begin
                    n_bad++; $display("FAIL rand_out dut%0d cyc%0d got=%b/%0d/%h exp=%b/%0d/%h", d, i,
                                      o_vld[d], o_gid[d], o_dout[d], e_vld[d], e_gid[d], e_dout[d]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; req = 4'h0; wen = 4'h0; din = 32'h0;
        model_reset();
        #1;
        test_reset();
        test_rr_q1();
        test_alternate();
        test_quota3();
        test_wen_skip();
        test_ready_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wc_rr_fifo_scheduler.md
# wc_rr_fifo_scheduler

Work-conserving round-robin read scheduler for four FIFO_8-style queues sharing one output port. Each cycle it picks one eligible non-empty queue, pulses its read enable, and presents that queue's data one cycle later with a valid strobe. It skips empty or write-busy queues, honours a downstream `ready`, and lets each port hold the output for up to `QUOTA` consecutive reads before rotating. It sits between the four input FIFOs and the shared consumer.

## Interface
- `DW`, 8, data width per queue.
- `QUOTA`, 1, max consecutive grants to one port before forced rotation; legal range 1..15.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-queue not-empty flag (bit i = queue i holds data).
- `wen`  in  4  per-queue write enable; a queue being written this cycle is ineligible (FIFO cannot read and write in the same cycle).
- `din`  in  4*DW  packed queue read data; queue i at `din[i*DW +: DW]`, valid the cycle after its `ren`.
- `ready`  in  1  downstream accepts a word next cycle.
- `ren`  out  4  one-hot or zero read enable to the queues, combinational from current state and inputs.
- `dout`  out  DW  `din` slice of the last granted queue when `valid`, else 0.
- `valid`  out  1  registered; `dout` carries a real word.
- `grant_id`  out  2  registered index of the queue that produced `dout`.

## Operation
- Eligible vector: `elig = req & ~wen`, and all zero when `ready`=0.
- Registers: `ptr[1:0]` (highest-priority port), `cnt[3:0]` (grants used by `ptr` in current burst), `valid`, `grant_id`.
- Pick: the first set bit of `elig` scanning `ptr, ptr+1, ptr+2, ptr+3` (mod 4). `ren` is one-hot on the picked port, or zero if `elig`=0.
- States (encoded by `cnt`):
  - IDLE (`cnt`=0)
  - BURST (`cnt`>0, holding `ptr`)
- On a grant to port p:
  - If p==`ptr` and `cnt`+1 < `QUOTA`: `cnt`<=`cnt`+1 and `ptr` holds (BURST).
  - Otherwise, or when p!=`ptr`: `ptr`<=p+1 mod 4 and `cnt`<=0 if `QUOTA`==1. If `QUOTA`>1 and p!=`ptr`: `ptr`<=p and `cnt`<=1.
  - A port reaching `QUOTA` grants: `ptr`<=p+1 mod 4 and `cnt`<=0.
- No grant with `ready`=1 (no eligible port): if `ptr`'s port is not eligible, `cnt`<=0 (burst abandoned) and `ptr` holds.
- `ready`=0: `ptr` and `cnt` hold, `ren`=0.
- Output regs: `valid`<=|`ren`; `grant_id`<=index of `ren` when |`ren`, else hold.
- `dout` = `valid` ? `din[grant_id*DW +: DW]` : 0.
- Counter width: `cnt` saturates logically at `QUOTA`-1 and never wraps.

## Timing
- Reset (async assert, released synchronously by clk domain): `ptr`=0, `cnt`=0, `valid`=0, `grant_id`=0. Consequently `ren`=0 while `rst`=1, and `dout`=0.
- Latency: `ren[i]` high in cycle t gives `valid`=1, `grant_id`=i and `dout`=queue i head in cycle t+1.
- Throughput: one word per cycle while eligible data exists and `ready`=1.
- `ready` low in cycle t gives `valid`=0 in t+1. A word already issued in t-1 is still presented in t (`ready` is a next-cycle acceptance).
- `wen[i]` and `req[i]` both high: port i is skipped this cycle with no `ptr` penalty beyond normal rotation.
- A queue draining mid-burst (`req` drops): rotation happens the same cycle, and no bubble occurs if another port is eligible.
- Reset mid-burst: all state is cleared immediately. The in-flight `valid` is dropped and no `ren` is asserted during reset.

## Structure
- Shared package:
  - `NPORT`=4
  - `PW`=2 (port index width)
  - the `QUOTA` legal-range constant
- Sub-module `rr_pick`: combinational rotating-priority encoder, with inputs `elig[3:0]` and `ptr[1:0]`, and outputs `gnt[3:0]` (one-hot) and `gid[1:0]`.
- Top level holds `ptr`/`cnt` update logic, output registers and the `dout` mux.

## Test plan
- Reset then `req`=4'b1111, `ready`=1, `QUOTA`=1, distinct data per queue → `ren` sequence 0001,0010,0100,1000,0001; `grant_id` 0,1,2,3 one cycle later with `valid`=1 each cycle.
- `req`=4'b0101, `QUOTA`=1 → `ren` alternates 0001/0100; ports 1 and 3 are never granted; no idle cycles.
- `QUOTA`=3, `req`=4'b1111 → each port is granted 3 consecutive times (`grant_id` 0,0,0,1,1,1,2,...). With `req[0]` dropped after 2 grants, the next grant goes to port 1 immediately.
- `req`=4'b0011, `wen`=4'b0001 for one cycle while `ptr`=0 → that cycle `ren`=0010. The next cycle `ren`=0001, since `ptr` advanced to 2 and wraps.
- `ready`=0 for 3 cycles mid-stream → `ren`=0 during those cycles and `valid`=0 the following cycles. `ptr`/`cnt` are unchanged, and the stream resumes at the same port.
- `rst` asserted asynchronously between edges during a burst with `QUOTA`=4 → `valid`, `grant_id`, `ptr`, `cnt` go to 0 without a clock and `ren`=0. After release the first grant goes to port 0.
